// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the ROM access arbiter.
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 12;
  localparam int ROM_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin arbiter: on a tie the requester that
// was not served last wins; a lone requester always wins.
module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = enable & req[0] & (~req[1] | last);
    grant[1] = enable & req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin sharing of a combinational ROM between instruction fetch (0) and
// data/constant load (1). Define ROM_ARB_STATS_EN to add saturating grant counters.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_q, last_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic [1:0]        grant;

  // Handshake: a request transfers on a rising edge where reqX_valid and
  // reqX_ready are both high; ready is only offered in IDLE to one requester.
  rr_arbiter2 u_rr (
    .req    ({req1_valid, req0_valid}),
    .last   (last_q),
    .enable (state_q == IDLE),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign rom_addr   = addr_q;
  assign busy       = (state_q == READ);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    owner_d      = owner_q;
    last_d       = last_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    case (state_q)
      IDLE: begin
        if (grant[0]) begin
          addr_d  = req0_addr;
          owner_d = 1'b0;
          last_d  = 1'b0;
          state_d = READ;
        end else if (grant[1]) begin
          addr_d  = req1_addr;
          owner_d = 1'b1;
          last_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        // rom_addr has been stable from addr_q for this whole cycle.
        state_d = IDLE;
        if (owner_q == 1'b0) begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = rom_data;
        end else begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = rom_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (grant[0] && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
    if (grant[1] && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`else
  // CNT_W only sizes the optional counters.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: drivers push expected responses into
// a queue, a negedge monitor pops and compares each response pulse.
module tb_rom_access_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        busy;

  logic [31:0] rom [0:4095];
  assign rom_data = rom[rom_addr];

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

`ifdef ROM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
  logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_busy;
  logic [31:0] s_rsp0_data, s_rsp1_data, s_rom_data;
  logic [11:0] s_rom_addr;
  logic [1:0]  s_cnt0, s_cnt1;
  assign s_rom_data = rom[s_rom_addr];

  rom_access_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(s_req0_ready),
    .rsp0_valid(s_rsp0_valid), .rsp0_data(s_rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(s_req1_ready),
    .rsp1_valid(s_rsp1_valid), .rsp1_data(s_rsp1_data),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data), .busy(s_busy),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );
`endif

  rom_access_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
`ifdef ROM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input logic id, input logic [31:0] data);
    logic [32:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL rsp_unexpected id=%0d data=0x%08h expected=no response", id, data);
    end else begin
      e = exp_q.pop_front();
      if (e !== {id, data}) begin
        failures++;
        $display("FAIL rsp_data actual id=%0d data=0x%08h expected id=%0d data=0x%08h",
                 id, data, e[32], e[31:0]);
      end
    end
  endtask

  // Monitor: handshake exclusivity every cycle, responses against the queue.
  always @(negedge clk) begin
    checks++;
    if ((req0_ready && req1_ready) || (busy && (req0_ready || req1_ready))) begin
      failures++;
      $display("FAIL ready_excl actual r0=%0b r1=%0b busy=%0b expected at most one ready, none in READ",
               req0_ready, req1_ready, busy);
    end
    if (rsp0_valid) check_rsp(1'b0, rsp0_data);
    if (rsp1_valid) check_rsp(1'b1, rsp1_data);
  end

  // Driver tasks
  task automatic set_req(input int id, input logic v, input logic [11:0] a);
    if (id == 0) begin
      req0_valid = v;
      req0_addr  = a;
    end else begin
      req1_valid = v;
      req1_addr  = a;
    end
  endtask

  task automatic wait_ready(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    check({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    check({tag, "_rsp0_data"}, rsp0_data, 32'd0);
    check({tag, "_rsp1_data"}, rsp1_data, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rom_addr"}, {20'd0, rom_addr}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Starts and ends just after a rising edge.
  task automatic single_read(input int id, input logic [11:0] a);
    bit ok;
    set_req(id, 1'b1, a);
    exp_q.push_back({id[0], rom[a]});
    wait_ready(id, ok);
    @(posedge clk);
    #1 set_req(id, 1'b0, a);
    @(negedge clk);
    check("busy_in_read", {31'd0, busy}, 32'd1);
    check("rom_addr_read", {20'd0, rom_addr}, {20'd0, a});
    @(negedge clk);
    check("rsp_latency", {31'd0, (id == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Tie with requester 0 expected to win, requester 1 served right after.
  task automatic dual_read(input logic [11:0] a0, input logic [11:0] a1);
    set_req(0, 1'b1, a0);
    set_req(1, 1'b1, a1);
    @(negedge clk);
    check("tie_ready0", {31'd0, req0_ready}, 32'd1);
    check("tie_ready1", {31'd0, req1_ready}, 32'd0);
    exp_q.push_back({1'b0, rom[a0]});
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    check("ready1_in_read", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check("ready1_after_read", {31'd0, req1_ready}, 32'd1);
    check("rsp0_at_n2", {31'd0, rsp0_valid}, 32'd1);
    exp_q.push_back({1'b1, rom[a1]});
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rsp1_at_n4", {31'd0, rsp1_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ok;
    int exp_id;
    int ngrants;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr = '0;
    req1_addr = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 32'hC0DE0000 | i;
    rom[0] = 32'h11223344;
    rom[1] = 32'hAABBCCDD;
    rom[3] = 32'hAABBCC21;
    do_reset();

    // Lone request from fetch, then data must hold after the pulse.
    single_read(0, 12'd1);
    repeat (3) @(negedge clk);
    check("rsp0_hold", rsp0_data, 32'hAABBCCDD);
    check("rsp1_untouched", rsp1_data, 32'd0);
    @(posedge clk);
    #1;

    // Tie straight after reset.
    do_reset();
    dual_read(12'd0, 12'd3);

    // Continuous dual requests alternate 0,1,0,1...
    exp_id = 0;
    ngrants = 0;
    set_req(0, 1'b1, 12'd6);
    set_req(1, 1'b1, 12'd7);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("alt_grant_id", {31'd0, req1_ready}, exp_id);
        exp_q.push_back({req1_ready, rom[req1_ready ? 7 : 6]});
        exp_id = exp_id ^ 1;
        ngrants++;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alt_grant_count", ngrants, 32'd8);
    repeat (3) @(posedge clk);
    #1;

    // Reset while a read of addr 4 is in flight.
    set_req(0, 1'b1, 12'd4);
    wait_ready(0, ok);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    rst = 1'b1;
    #1 check("async_busy_clear", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_reset_outputs("mid_read_reset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    dual_read(12'd8, 12'd9);

    // Requester 1 gives up before ready while requester 0 is in flight.
    set_req(0, 1'b1, 12'd2);
    exp_q.push_back({1'b0, rom[2]});
    wait_ready(0, ok);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    set_req(1, 1'b1, 12'd5);
    @(negedge clk);
    check("drop_ready1_in_read", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    check("drop_rsp0", {31'd0, rsp0_valid}, 32'd1);
    repeat (3) @(negedge clk);
    check("drop_no_read_addr5", {20'd0, rom_addr}, 32'd2);
    @(posedge clk);
    #1;

    // Top of the address range.
    single_read(1, 12'hFFF);

`ifdef ROM_ARB_STATS_EN
    do_reset();
    single_read(0, 12'd10);
    single_read(0, 12'd11);
    single_read(0, 12'd12);
    single_read(1, 12'd13);
    single_read(1, 12'd14);
    check("cnt0_three", {16'd0, grant_cnt0}, 32'd3);
    check("cnt1_two", {16'd0, grant_cnt1}, 32'd2);
    check("sat_cnt0_three", {30'd0, s_cnt0}, 32'd3);
    check("sat_cnt1_two", {30'd0, s_cnt1}, 32'd2);
    single_read(0, 12'd15);
    single_read(0, 12'd16);
    check("cnt0_five", {16'd0, grant_cnt0}, 32'd5);
    check("sat_cnt0_saturated", {30'd0, s_cnt0}, 32'd3);
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single-port, combinational, word-addressed instruction/constant ROM (12-bit address, 32-bit data) between two requesters.
- Requester 0 is instruction fetch. Requester 1 is the data/constant load path.
- Arbitration is round-robin. The block registers the ROM address and the read data.
- Each requester gets a valid/ready request channel and a one-cycle response pulse.

Parameters:
- ADDR_W, 12, ROM word-address width.
- DATA_W, 32, ROM word width.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req0_valid  input  1  requester 0 read request.
- req0_addr  input  ADDR_W  requester 0 word address.
- req0_ready  output  1  requester 0 request accepted this cycle.
- rsp0_valid  output  1  requester 0 read data valid, one-cycle pulse.
- rsp0_data  output  DATA_W  requester 0 read data.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as above, for requester 1.
- rom_addr  output  ADDR_W  address to the ROM.
- rom_data  input  DATA_W  combinational ROM read data.
- busy  output  1  read in flight (state READ).

Behaviour:
- Reset values: state=IDLE, addr_q=0, owner_q=0, last_q=1 (requester 0 wins the first tie). All rsp*_valid=0, all rsp*_data=0, busy=0, rom_addr=0.
- FSM states: IDLE and READ.
- IDLE:
  - Grant is combinational. If only one requester is valid, that one is granted.
  - If both are valid, the requester that is not last_q is granted.
  - reqX_ready = (state==IDLE) && grantX. At most one ready is high per cycle.
  - On handshake: addr_q<=reqX_addr, owner_q<=X, last_q<=X, state->READ.
  - No valid request: stay in IDLE, all state registers hold.
- READ:
  - rom_addr=addr_q.
  - rspX_data<=rom_data for X=owner_q. rspX_valid<=1 on the next edge. state->IDLE.
  - Both ready outputs are 0.
- rom_addr is driven from addr_q in every state, so it holds its last value while idle.
- Latency: handshake edge at cycle N, rsp valid during cycle N+2. Peak throughput is 1 read per 2 cycles.
- rspX_valid is high for exactly one cycle. rspX_data holds its value until the next response to that requester.
- Response channels have no backpressure; the requester must accept the pulse.
- A requester must hold valid and addr stable until it sees ready. Dropping valid before ready is legal and no read is performed.
- Simultaneous requests, alternating grants: for continuous dual requests the grant sequence is 0,1,0,1,... Neither requester waits more than one other transaction.
- Address is a word index taken modulo 2^ADDR_W. No range check and no wrap logic beyond the width.
- Reset mid-READ: the in-flight read is discarded, no rsp pulse is produced, and last_q returns to 1.
- busy = (state==READ).

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- Defined:
  - Adds output ports grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each counter increments on its requester's handshake and saturates at all-ones.
  - Both counters clear on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package rom_arb_pkg holds:
  - typedef enum logic {IDLE, READ} arb_state_t.
  - typedef logic req_id_t (0 or 1).
  - localparams ROM_ADDR_W=12 and ROM_DATA_W=32. The module parameters default to these.
- Sub-module rr_arbiter2 is natural. It is purely combinational: inputs req[1:0], last, enable; output grant[1:0]. It is instantiated once. The FSM and registers stay in rom_access_arbiter.

Test Plan:
- ROM word1=0xAABBCCDD. req0 addr=1 alone -> req0_ready at cycle N; rsp0_valid=1 with rsp0_data=0xAABBCCDD at N+2; rsp1_valid stays 0.
- Both valid after reset: req0 addr=0, req1 addr=3 (ROM 0x11223344 and 0xAABBCC21) -> req0 granted first; rsp0_data=0x11223344 at N+2; req1 granted at N+2; rsp1_data=0xAABBCC21 at N+4.
- Both held valid for 8 cycles -> grants strictly alternate 0,1,0,1. Ready is never high on both ports at once. Ready is never high in READ.
- Assert rst during READ of addr=4 -> no rsp pulse; all outputs zero. After release, a tie grants requester 0.
- req1 valid addr=5 deasserted before ready while req0 is in flight -> no read for addr 5; no rsp1 pulse.
- With ROM_ARB_STATS_EN: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2. With CNT_W forced to 2 and 5 grants to req0 -> grant_cnt0 saturates at 3.
